except_collect: RTL
===================

// Module: except_collect
// PURPOSE
//  MEM->CP0 exception producer for the dual-issue pipe. Per lane: priority-encodes raw fault flags
//  into the EXCEPT_WD exceptinfo word, then registers the two lane records towards CP0.
//  Handles CP0's flush response: captures the redirect target and flushes the pipe.
//  Holds the redirect until fetch accepts it. Also keeps a saturating exception counter.
// PARAMETERS
//  EXC_CNT_W   16   width of saturating exception counter
// PORTS
//  clk            in   1    clock, all state on posedge
//  resetn         in   1    asynchronous, active-low reset
//  stall          in   1    MEM stage stalled; hold output records
//  i{1,2}_valid   in   1    lane carries a real instruction
//  i{1,2}_pc      in   32   lane PC
//  i{1,2}_ds      in   1    lane is in a branch delay slot
//  i{1,2}_cp0_we  in   1    mtc0
//  i{1,2}_waddr   in   5    CP0 write reg
//  i{1,2}_raddr   in   5    CP0 read reg
//  i{1,2}_exc     in   8    {eret,ades,adel_d,ov,brk,sys,ri,adel_f} raw flags
//  i{1,2}_rt      in   32   rt data (mtc0 source)
//  i{1,2}_badaddr in   32   data address of load/store
//  exceptinfo_o{1,2} out 44 {ds[43],we[42],waddr[41:37],raddr[36:32],excepttype[31:0]} to CP0
//  current_pc_o{1,2} out 32 registered lane PC
//  rt_rdata_o{1,2}   out 32 registered rt data
//  bad_addr_o{1,2}   out 32 registered bad address (PC for adel_f)
//  to_be_flushed  in   1    CP0 exception taken (combinational from exceptinfo_o*)
//  new_pc         in   32   CP0 vector
//  epc_i          in   32   current CP0 EPC (ERET target)
//  flush          out  1    one-cycle pipeline flush pulse
//  redirect_valid out  1    redirect PC pending to fetch
//  redirect_pc    out  32   redirect target
//  redirect_ready in   1    fetch accepts redirect
//  exc_count      out  EXC_CNT_W  exceptions taken, saturating
// BEHAVIOUR
//  Reset (resetn=0, async): all outputs 0, FSM=IDLE, exc_count=0.
//  Encode, per lane, combinational; a lane with valid=0 gives all-zero record:
//  - excepttype priority: adel_f>`PCASSERT, ri>`INVALIDINST, sys>`SYSCALL, brk>`BREAK,
//    ov>`OV, adel_d>`LOADASSERT, ades>`STOREASSERT, eret>`ERET; none -> 32'b0.
//  - ds/we/waddr/raddr packed whatever excepttype is; we forced 0 if excepttype!=0.
//  - bad_addr = pc if adel_f wins, else badaddr.
//  - lane-2 record forced all-zero when lane-1 excepttype!=0 (precise ordering).
//  Output regs, 1-cycle latency: edge after inputs, records appear on *_o*.
//  - stall=1: hold. Clear to zero at edge where to_be_flushed=1 (overrides stall) or FSM!=IDLE.
//    A record is therefore seen by CP0 exactly once.
//  FSM IDLE/FLUSH/REDIR:
//  - IDLE: to_be_flushed=1 at edge -> FLUSH; capture target = epc_i if winning type is `ERET, else new_pc.
//    Winning record is lane 1 if lane-1 excepttype!=0, else lane 2.
//    exc_count += 1 unless `ERET; saturates at all-ones.
//  - FLUSH: flush=1 for exactly this cycle; redirect_valid=1, redirect_pc=target; -> REDIR.
//  - REDIR: redirect_valid=1 until redirect_ready=1 at edge -> IDLE; redirect_pc stable.
//  - to_be_flushed ignored in FLUSH/REDIR (records are zero anyway).
//  - redirect_ready in FLUSH also completes handshake: FLUSH -> IDLE directly.
//  Latency: exception inputs cycle N -> CP0 sees cycle N+1 -> flush and redirect_valid in N+2.
//  Reset mid-REDIR: redirect dropped, FSM IDLE immediately.
// TESTING
//  1 lane1 valid ov=1 pc=0xBFC0_0100, ready=1
//    -> N+1: exceptinfo_o1[31:0]=`OV, o2=0; N+2: flush=1, redirect_pc=0xBFC0_0380, count=1.
//  2 lane1 ri+sys both set, lane2 brk
//    -> excepttype_o1=`INVALIDINST, exceptinfo_o2=44'b0.
//  3 lane2 adel_f pc=0x8000_0002, lane1 clean mtc0 waddr=12 -> o1 we=1 excepttype=0;
//    o2 excepttype=`PCASSERT, bad_addr_o2=0x8000_0002.
//  4 lane1 eret, epc_i=0x8000_1234, ready low 3 cycles
//    -> redirect_pc=0x8000_1234 held 4 cycles, count unchanged, single flush pulse.
//  5 stall=1 with exception record present, CP0 flushes
//    -> record cleared next edge despite stall; no second flush.
//  6 force count to 0xFFFF, take exception -> stays 0xFFFF; assert resetn=0 in REDIR -> all outputs 0 async.

Source files
------------

// File: rtl/except_collect.sv
// MEM->CP0 exception producer: per-lane priority encode, registered records towards CP0,
// flush/redirect sequencing on CP0's response and a saturating exception counter.
module except_collect #(
    parameter int unsigned EXC_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stall,
    input  logic                 i1_valid,
    input  logic [31:0]          i1_pc,
    input  logic                 i1_ds,
    input  logic                 i1_cp0_we,
    input  logic [4:0]           i1_waddr,
    input  logic [4:0]           i1_raddr,
    input  logic [7:0]           i1_exc,
    input  logic [31:0]          i1_rt,
    input  logic [31:0]          i1_badaddr,
    input  logic                 i2_valid,
    input  logic [31:0]          i2_pc,
    input  logic                 i2_ds,
    input  logic                 i2_cp0_we,
    input  logic [4:0]           i2_waddr,
    input  logic [4:0]           i2_raddr,
    input  logic [7:0]           i2_exc,
    input  logic [31:0]          i2_rt,
    input  logic [31:0]          i2_badaddr,
    output logic [43:0]          exceptinfo_o1,
    output logic [43:0]          exceptinfo_o2,
    output logic [31:0]          current_pc_o1,
    output logic [31:0]          current_pc_o2,
    output logic [31:0]          rt_rdata_o1,
    output logic [31:0]          rt_rdata_o2,
    output logic [31:0]          bad_addr_o1,
    output logic [31:0]          bad_addr_o2,
    input  logic                 to_be_flushed,
    input  logic [31:0]          new_pc,
    input  logic [31:0]          epc_i,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic [EXC_CNT_W-1:0] exc_count
);

    localparam logic [31:0] PCASSERT    = 32'h0000_0004;
    localparam logic [31:0] INVALIDINST = 32'h0000_000a;
    localparam logic [31:0] SYSCALL     = 32'h0000_0008;
    localparam logic [31:0] BREAK       = 32'h0000_0009;
    localparam logic [31:0] OV          = 32'h0000_000c;
    localparam logic [31:0] LOADASSERT  = 32'h0000_0014;
    localparam logic [31:0] STOREASSERT = 32'h0000_0005;
    localparam logic [31:0] ERET        = 32'h0000_000e;

    typedef enum logic [1:0] {StIdle, StFlush, StRedir} state_e;
    state_e state_q, state_d;

    // Flag order {eret,ades,adel_d,ov,brk,sys,ri,adel_f}; lowest bit has highest priority.
    function automatic logic [31:0] enc_type(input logic [7:0] exc);
        if (exc[0])      return PCASSERT;
        else if (exc[1]) return INVALIDINST;
        else if (exc[2]) return SYSCALL;
        else if (exc[3]) return BREAK;
        else if (exc[4]) return OV;
        else if (exc[5]) return LOADASSERT;
        else if (exc[6]) return STOREASSERT;
        else if (exc[7]) return ERET;
        else             return 32'b0;
    endfunction

    logic [31:0] type1, type2, win_type;
    logic [43:0] info1, info2;
    logic [31:0] pc1, pc2, rt1, rt2, bad1, bad2;
    logic        lane2_ok, clear;

    always_comb begin
        type1    = i1_valid ? enc_type(i1_exc) : 32'b0;
        info1    = 44'b0;
        pc1      = 32'b0;
        rt1      = 32'b0;
        bad1     = 32'b0;
        if (i1_valid) begin
            info1 = {i1_ds, i1_cp0_we & (type1 == 32'b0), i1_waddr, i1_raddr, type1};
            pc1   = i1_pc;
            rt1   = i1_rt;
            bad1  = i1_exc[0] ? i1_pc : i1_badaddr;
        end
        // Lane 2 is younger: suppress it entirely when lane 1 faults.
        lane2_ok = i2_valid && (type1 == 32'b0);
        type2    = lane2_ok ? enc_type(i2_exc) : 32'b0;
        info2    = 44'b0;
        pc2      = 32'b0;
        rt2      = 32'b0;
        bad2     = 32'b0;
        if (lane2_ok) begin
            info2 = {i2_ds, i2_cp0_we & (type2 == 32'b0), i2_waddr, i2_raddr, type2};
            pc2   = i2_pc;
            rt2   = i2_rt;
            bad2  = i2_exc[0] ? i2_pc : i2_badaddr;
        end
    end

    assign clear    = to_be_flushed || (state_q != StIdle);
    assign win_type = (exceptinfo_o1[31:0] != 32'b0) ? exceptinfo_o1[31:0] : exceptinfo_o2[31:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exceptinfo_o1 <= 44'b0;
            exceptinfo_o2 <= 44'b0;
            current_pc_o1 <= 32'b0;
            current_pc_o2 <= 32'b0;
            rt_rdata_o1   <= 32'b0;
            rt_rdata_o2   <= 32'b0;
            bad_addr_o1   <= 32'b0;
            bad_addr_o2   <= 32'b0;
        end else if (clear) begin
            exceptinfo_o1 <= 44'b0;
            exceptinfo_o2 <= 44'b0;
            current_pc_o1 <= 32'b0;
            current_pc_o2 <= 32'b0;
            rt_rdata_o1   <= 32'b0;
            rt_rdata_o2   <= 32'b0;
            bad_addr_o1   <= 32'b0;
            bad_addr_o2   <= 32'b0;
        end else if (!stall) begin
            exceptinfo_o1 <= info1;
            exceptinfo_o2 <= info2;
            current_pc_o1 <= pc1;
            current_pc_o2 <= pc2;
            rt_rdata_o1   <= rt1;
            rt_rdata_o2   <= rt2;
            bad_addr_o1   <= bad1;
            bad_addr_o2   <= bad2;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (to_be_flushed) state_d = StFlush;
            StFlush: state_d = redirect_ready ? StIdle : StRedir;
            StRedir: if (redirect_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign flush          = (state_q == StFlush);
    assign redirect_valid = (state_q != StIdle);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            redirect_pc <= 32'b0;
            exc_count   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && to_be_flushed) begin
                redirect_pc <= (win_type == ERET) ? epc_i : new_pc;
                if (win_type != ERET && exc_count != '1) begin
                    exc_count <= exc_count + EXC_CNT_W'(1);
                end
            end
        end
    end

endmodule
